// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between
// NUM_REQ byte producers, with optional packet lock and a tx_done watchdog.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned TX_TIMEOUT = 4096,
  parameter int unsigned LOCK_IDLE  = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ack,
  output logic                         tx_start,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         grant_valid,
  output logic                         locked,
  output logic                         timeout_err
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned WD_W = $clog2(TX_TIMEOUT + 1);
  localparam int unsigned LI_W = $clog2(LOCK_IDLE + 1);

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_DONE = 1'b1
  } state_t;

  state_t                 state;
  logic [ID_W-1:0]        last_ptr;
  logic [WD_W-1:0]        wd_cnt;
  logic [LI_W-1:0]        li_cnt;

  logic [NUM_REQ-1:0]     own_mask_c;
  logic [NUM_REQ-1:0]     cand_c;
  logic [2*NUM_REQ-1:0]   dbl_c;
  logic                   found_c;
  int unsigned            w_c;
  logic [ID_W-1:0]        win_c;
  logic [DATA_W-1:0]      win_data_c;
  logic                   win_last_c;
  logic                   launch_c;

  // Winner search: first candidate at or above (last winner + 1), wrapping.
  always_comb begin
    own_mask_c = NUM_REQ'(1) << grant_id;
    cand_c     = locked ? (req & own_mask_c) : req;
    dbl_c      = {cand_c, cand_c} >> (32'(last_ptr) + 32'd1);
    found_c    = 1'b0;
    w_c        = 32'd0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found_c && dbl_c[k]) begin
        found_c = 1'b1;
        w_c     = 32'(last_ptr) + 32'd1 + k;
      end
    end
    if (w_c >= NUM_REQ) w_c = w_c - NUM_REQ;
    win_c      = ID_W'(w_c);
    win_data_c = '0;
    win_last_c = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win_c == ID_W'(i)) begin
        win_data_c = req_data[i*DATA_W +: DATA_W];
        win_last_c = req_last[i];
      end
    end
    launch_c = found_c && !tx_busy;
  end

  // Arbitration FSM with registered outputs, watchdog and lock-idle counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      req_ack     <= '0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      locked      <= 1'b0;
      timeout_err <= 1'b0;
      last_ptr    <= ID_W'(NUM_REQ - 1);
      wd_cnt      <= '0;
      li_cnt      <= '0;
    end else begin
      req_ack     <= '0;
      tx_start    <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (launch_c) begin
            tx_start    <= 1'b1;
            req_ack     <= NUM_REQ'(1) << win_c;
            tx_data     <= win_data_c;
            grant_id    <= win_c;
            grant_valid <= 1'b1;
            locked      <= ~win_last_c;
            li_cnt      <= '0;
            wd_cnt      <= WD_W'(1);
            state       <= WAIT_DONE;
          end else if (!tx_busy && locked) begin
            // Owner holds the lock but is not requesting: count toward release.
            if (li_cnt == LI_W'(LOCK_IDLE - 1)) begin
              locked <= 1'b0;
              li_cnt <= '0;
            end else begin
              li_cnt <= li_cnt + LI_W'(1);
            end
          end
        end
        WAIT_DONE: begin
          if (tx_done) begin
            grant_valid <= 1'b0;
            last_ptr    <= grant_id;
            wd_cnt      <= '0;
            state       <= IDLE;
          end else if (wd_cnt >= WD_W'(TX_TIMEOUT)) begin
            timeout_err <= 1'b1;
            grant_valid <= 1'b0;
            locked      <= 1'b0;
            last_ptr    <= grant_id;
            wd_cnt      <= '0;
            state       <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester/transmitter agents on the
// falling edge, scenario tasks sampling one delay unit after the rising edge.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 16;
  localparam int unsigned LI = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req;
  logic [NR-1:0] req_last;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0] req_ack;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          tx_busy;
  logic          tx_done;
  logic [1:0]    grant_id;
  logic          grant_valid;
  logic          locked;
  logic          timeout_err;

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .TX_TIMEOUT(TO), .LOCK_IDLE(LI)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_data(req_data),
    .req_ack(req_ack), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .tx_done(tx_done), .grant_id(grant_id), .grant_valid(grant_valid),
    .locked(locked), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
    logic       lk;
  } launch_t;

  launch_t exp_q[$];
  launch_t exp_l;
  launch_t obs_l;
  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] src_data [NR][16];
  logic       src_last [NR][16];
  int         src_wr [NR];
  int         src_rd [NR];
  bit         done_en;
  int         done_delay;
  bit         pend;
  int         dcnt;

  task automatic add_byte(input int i, input logic [7:0] d, input logic l);
    src_data[i][src_wr[i]] = d;
    src_last[i][src_wr[i]] = l;
    src_wr[i]++;
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(posedge clk); #1;
      if (tx_start) seen = 1'b1;
    end
  endtask

  // Requester and transmitter models, updated mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (!rst) pend = 1'b0;
      else if (tx_start) begin
        pend = done_en;
        dcnt = 0;
      end else if (pend) begin
        dcnt++;
        if (dcnt == done_delay) begin
          tx_done = 1'b1;
          pend    = 1'b0;
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (req_ack[i]) src_rd[i]++;
        if (src_rd[i] < src_wr[i]) begin
          req[i]              = 1'b1;
          req_data[i*DW +: DW] = src_data[i][src_rd[i]];
          req_last[i]         = src_last[i][src_rd[i]];
        end else begin
          req[i]              = 1'b0;
          req_data[i*DW +: DW] = '0;
          req_last[i]         = 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_cmp++;
    if ({req_ack, tx_start, grant_id, grant_valid, locked, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got ack=%b start=%b id=%0d gv=%b lk=%b to=%b want all 0",
               req_ack, tx_start, grant_id, grant_valid, locked, timeout_err);
    end
    n_cmp++;
    if (tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data: got %h want 00", tx_data);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    bit seen;
    int t0, ts;
    done_en = 1'b1; done_delay = 10;
    add_byte(1, 8'hA5, 1'b1);
    exp_q.push_back({2'd1, 8'hA5, 1'b0});
    t0 = cyc;
    wait_start(5, seen);
    n_cmp++;
    if (!seen || cyc != t0 + 1) begin
      n_err++;
      $display("FAIL single_latency: got seen=%0d after %0d cycles want 1 cycle", seen, cyc - t0);
    end
    exp_l = exp_q.pop_front();
    obs_l = {grant_id, tx_data, locked};
    n_cmp++;
    if (obs_l !== exp_l) begin
      n_err++;
      $display("FAIL single_launch: got id=%0d data=%h lk=%b want id=%0d data=%h lk=%b",
               obs_l.id, obs_l.data, obs_l.lk, exp_l.id, exp_l.data, exp_l.lk);
    end
    n_cmp++;
    if (req_ack !== 4'b0010) begin
      n_err++;
      $display("FAIL single_ack: got %b want 0010", req_ack);
    end
    ts = cyc;
    for (int n = 0; n < 30 && grant_valid; n++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (grant_valid !== 1'b0 || cyc != ts + 11 || locked !== 1'b0 || tx_data !== 8'hA5) begin
      n_err++;
      $display("FAIL single_release: got gv=%b after %0d lk=%b data=%h want gv=0 after 11 lk=0 data=a5",
               grant_valid, cyc - ts, locked, tx_data);
    end
  endtask

  task automatic test_fairness();
    bit seen;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    done_en = 1'b1; done_delay = 5;
    add_byte(0, 8'h10, 1'b1);
    add_byte(0, 8'h14, 1'b1);
    add_byte(1, 8'h11, 1'b1);
    add_byte(2, 8'h12, 1'b1);
    add_byte(3, 8'h13, 1'b1);
    exp_q.push_back({2'd0, 8'h10, 1'b0});
    exp_q.push_back({2'd1, 8'h11, 1'b0});
    exp_q.push_back({2'd2, 8'h12, 1'b0});
    exp_q.push_back({2'd3, 8'h13, 1'b0});
    exp_q.push_back({2'd0, 8'h14, 1'b0});
    for (int n = 0; n < 5; n++) begin
      wait_start(30, seen);
      exp_l = exp_q.pop_front();
      obs_l = {grant_id, tx_data, locked};
      n_cmp++;
      if (!seen || obs_l !== exp_l) begin
        n_err++;
        $display("FAIL fair_launch%0d: got seen=%0d id=%0d data=%h lk=%b want id=%0d data=%h lk=%b",
                 n, seen, obs_l.id, obs_l.data, obs_l.lk, exp_l.id, exp_l.data, exp_l.lk);
      end
      n_cmp++;
      if (req_ack !== (4'b0001 << exp_l.id)) begin
        n_err++;
        $display("FAIL fair_ack%0d: got %b want one-hot bit %0d", n, req_ack, exp_l.id);
      end
    end
  endtask

  task automatic test_lock();
    bit seen;
    add_byte(1, 8'h21, 1'b1);
    exp_q.push_back({2'd1, 8'h21, 1'b0});
    wait_start(30, seen);
    exp_l = exp_q.pop_front();
    obs_l = {grant_id, tx_data, locked};
    n_cmp++;
    if (!seen || obs_l !== exp_l) begin
      n_err++;
      $display("FAIL lock_leadin: got seen=%0d id=%0d data=%h want id=%0d data=%h",
               seen, obs_l.id, obs_l.data, exp_l.id, exp_l.data);
    end
    add_byte(2, 8'h31, 1'b0);
    add_byte(2, 8'h32, 1'b0);
    add_byte(2, 8'h33, 1'b1);
    add_byte(0, 8'h41, 1'b1);
    add_byte(3, 8'h43, 1'b1);
    exp_q.push_back({2'd2, 8'h31, 1'b1});
    exp_q.push_back({2'd2, 8'h32, 1'b1});
    exp_q.push_back({2'd2, 8'h33, 1'b0});
    exp_q.push_back({2'd3, 8'h43, 1'b0});
    exp_q.push_back({2'd0, 8'h41, 1'b0});
    for (int n = 0; n < 5; n++) begin
      wait_start(30, seen);
      exp_l = exp_q.pop_front();
      obs_l = {grant_id, tx_data, locked};
      n_cmp++;
      if (!seen || obs_l !== exp_l) begin
        n_err++;
        $display("FAIL lock_launch%0d: got seen=%0d id=%0d data=%h lk=%b want id=%0d data=%h lk=%b",
                 n, seen, obs_l.id, obs_l.data, obs_l.lk, exp_l.id, exp_l.data, exp_l.lk);
      end
    end
  endtask

  task automatic test_watchdog();
    bit seen;
    int ts, errs, rel;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
    end
    done_en = 1'b0;
    add_byte(1, 8'h51, 1'b1);
    add_byte(2, 8'h52, 1'b1);
    exp_q.push_back({2'd1, 8'h51, 1'b0});
    exp_q.push_back({2'd2, 8'h52, 1'b0});
    wait_start(10, seen);
    exp_l = exp_q.pop_front();
    obs_l = {grant_id, tx_data, locked};
    n_cmp++;
    if (!seen || obs_l !== exp_l) begin
      n_err++;
      $display("FAIL wd_launch: got seen=%0d id=%0d data=%h want id=%0d data=%h",
               seen, obs_l.id, obs_l.data, exp_l.id, exp_l.data);
    end
    ts = cyc;
    for (int n = 0; n < 40 && !timeout_err; n++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (timeout_err !== 1'b1 || cyc != ts + 16 || grant_valid !== 1'b0 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL wd_timeout: got to=%b after %0d gv=%b lk=%b want to=1 after 16 gv=0 lk=0",
               timeout_err, cyc - ts, grant_valid, locked);
    end
    done_en = 1'b1; done_delay = 15;
    wait_start(5, seen);
    exp_l = exp_q.pop_front();
    obs_l = {grant_id, tx_data, locked};
    n_cmp++;
    if (!seen || cyc != ts + 17 || obs_l !== exp_l) begin
      n_err++;
      $display("FAIL wd_next: got seen=%0d at %0d id=%0d want id=%0d at 17",
               seen, cyc - ts, obs_l.id, exp_l.id);
    end
    ts = cyc; errs = 0; rel = -1;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      if (timeout_err) errs++;
      if (!grant_valid && rel < 0) rel = cyc - ts;
    end
    n_cmp++;
    if (errs != 0 || rel != 16) begin
      n_err++;
      $display("FAIL wd_done_edge: got errs=%0d release=%0d want errs=0 release=16", errs, rel);
    end
  endtask

  task automatic test_stall_lock_idle();
    bit seen;
    int starts, ts;
    tx_busy = 1'b1; done_en = 1'b1; done_delay = 5;
    add_byte(3, 8'h63, 1'b1);
    exp_q.push_back({2'd3, 8'h63, 1'b0});
    starts = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (tx_start) starts++;
    end
    n_cmp++;
    if (starts != 0) begin
      n_err++;
      $display("FAIL stall_hold: got %0d starts want 0", starts);
    end
    tx_busy = 1'b0;
    ts = cyc;
    wait_start(3, seen);
    exp_l = exp_q.pop_front();
    obs_l = {grant_id, tx_data, locked};
    n_cmp++;
    if (!seen || cyc != ts + 1 || obs_l !== exp_l) begin
      n_err++;
      $display("FAIL stall_release: got seen=%0d at %0d id=%0d data=%h want id=%0d data=%h at 1",
               seen, cyc - ts, obs_l.id, obs_l.data, exp_l.id, exp_l.data);
    end
    add_byte(0, 8'h70, 1'b0);
    add_byte(1, 8'h71, 1'b1);
    exp_q.push_back({2'd0, 8'h70, 1'b1});
    exp_q.push_back({2'd1, 8'h71, 1'b0});
    wait_start(20, seen);
    exp_l = exp_q.pop_front();
    obs_l = {grant_id, tx_data, locked};
    n_cmp++;
    if (!seen || obs_l !== exp_l) begin
      n_err++;
      $display("FAIL lockidle_launch: got seen=%0d id=%0d lk=%b want id=%0d lk=%b",
               seen, obs_l.id, obs_l.lk, exp_l.id, exp_l.lk);
    end
    ts = cyc;
    for (int n = 0; n < 30 && locked; n++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (locked !== 1'b0 || cyc != ts + 14) begin
      n_err++;
      $display("FAIL lockidle_drop: got lk=%b after %0d want lk=0 after 14", locked, cyc - ts);
    end
    wait_start(3, seen);
    exp_l = exp_q.pop_front();
    obs_l = {grant_id, tx_data, locked};
    n_cmp++;
    if (!seen || cyc != ts + 15 || obs_l !== exp_l) begin
      n_err++;
      $display("FAIL lockidle_next: got seen=%0d at %0d id=%0d want id=%0d at 15",
               seen, cyc - ts, obs_l.id, exp_l.id);
    end
    for (int n = 0; n < 20 && grant_valid; n++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_async_reset();
    bit seen;
    done_en = 1'b0;
    add_byte(2, 8'h82, 1'b1);
    exp_q.push_back({2'd2, 8'h82, 1'b0});
    wait_start(10, seen);
    exp_l = exp_q.pop_front();
    obs_l = {grant_id, tx_data, locked};
    n_cmp++;
    if (!seen || obs_l !== exp_l || grant_valid !== 1'b1) begin
      n_err++;
      $display("FAIL arst_launch: got seen=%0d id=%0d data=%h gv=%b want id=%0d data=%h gv=1",
               seen, obs_l.id, obs_l.data, grant_valid, exp_l.id, exp_l.data);
    end
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({req_ack, tx_start, tx_data, grant_id, grant_valid, locked, timeout_err} !== '0) begin
      n_err++;
      $display("FAIL arst_clear: got ack=%b start=%b data=%h id=%0d gv=%b lk=%b to=%b want all 0",
               req_ack, tx_start, tx_data, grant_id, grant_valid, locked, timeout_err);
    end
    #2;
    rst = 1'b1;
    done_en = 1'b1; done_delay = 5;
    add_byte(0, 8'h90, 1'b1);
    add_byte(3, 8'h93, 1'b1);
    exp_q.push_back({2'd0, 8'h90, 1'b0});
    exp_q.push_back({2'd3, 8'h93, 1'b0});
    for (int n = 0; n < 2; n++) begin
      wait_start(30, seen);
      exp_l = exp_q.pop_front();
      obs_l = {grant_id, tx_data, locked};
      n_cmp++;
      if (!seen || obs_l !== exp_l) begin
        n_err++;
        $display("FAIL arst_after%0d: got seen=%0d id=%0d data=%h want id=%0d data=%h",
                 n, seen, obs_l.id, obs_l.data, exp_l.id, exp_l.data);
      end
    end
  endtask

  initial begin
    req = '0; req_last = '0; req_data = '0;
    tx_busy = 1'b0; tx_done = 1'b0;
    done_en = 1'b0; done_delay = 5; pend = 1'b0; dcnt = 0;
    for (int i = 0; i < NR; i++) begin
      src_wr[i] = 0;
      src_rd[i] = 0;
    end
    test_reset();
    test_single();
    test_fairness();
    test_lock();
    test_watchdog();
    test_stall_lock_idle();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Hard stop so a stuck scenario cannot hang the run.
  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion want completion before 500000");
    $fatal(1);
  end

endmodule
